imem_responder: RTL and testbench
=================================

// Module: imem_responder
// PURPOSE
//   Instruction-memory responder: target end of the fetch interface driven by the PC unit.
//   Accepts word fetch requests (byte address) via valid/ready and returns the 32-bit
//   instruction after a fixed pipeline latency, with a response FIFO absorbing back-pressure.
//   Provides a word-write load port for program preload by the bench or boot logic.
// PARAMETERS
//   DEPTH_WORDS  256  instruction words stored; addressable range 0 .. 4*DEPTH_WORDS-4
//   LATENCY      2    cycles from request accept to earliest resp_valid; legal 1..4
//   RESP_DEPTH   4    response FIFO entries; also the max outstanding requests; >= 1
// PORTS
//   clk         in   1   clock, all state on rising edge
//   rst_n       in   1   asynchronous active-low reset
//   req_valid   in   1   fetch request valid
//   req_ready   out  1   responder can accept a request this cycle
//   req_addr    in   32  byte address of requested instruction
//   resp_valid  out  1   response valid
//   resp_ready  in   1   consumer accepts response this cycle
//   resp_instr  out  32  instruction word; 32'h0 when resp_err=1
//   resp_addr   out  32  req_addr echoed for this response
//   resp_err    out  1   request misaligned (addr[1:0]!=0) or out of range
//   ld_en       in   1   load-port write enable
//   ld_addr     in   $clog2(DEPTH_WORDS)  word index to write
//   ld_data     in   32  word to write
//   busy        out  1   any request in pipeline or FIFO
// BEHAVIOUR
//   Clock clk; reset rst_n is asynchronous, active-low.
//   Reset: resp_valid=0, resp_err=0, resp_instr=0, resp_addr=0, busy=0, req_ready=1;
//     pipeline valids, FIFO pointers, outstanding counter cleared. Memory array NOT reset.
//   Reset mid-operation: all in-flight requests and queued responses are dropped, none emitted.
//   Accept: req_valid & req_ready on a rising edge. req_ready = (outstanding < RESP_DEPTH),
//     outstanding = requests in pipeline + FIFO entries; combinational only on state, never on req_valid.
//   Read: memory indexed by req_addr[2+:$clog2(DEPTH_WORDS)], sampled in accept cycle.
//   Errors checked at accept: addr[1:0]!=0 or (addr>>2)>=DEPTH_WORDS -> resp_err=1, resp_instr=0.
//   Pipeline: LATENCY-stage shift of {valid,instr,addr,err}; stage exit pushes into FIFO.
//   Output = FIFO head; resp_valid = FIFO non-empty. With FIFO empty and resp_ready=1,
//     response from request accepted at edge N is valid in cycle after edge N+LATENCY-1
//     (LATENCY=1: valid the cycle after accept). Back-to-back: one response per cycle.
//   Pop on resp_valid & resp_ready. While resp_valid=1 & resp_ready=0, resp_* held stable.
//   Responses strictly in request order. Push and pop same cycle allowed, count unchanged.
//   FIFO cannot overflow: credit rule guarantees space for every pipeline exit.
//   outstanding: +1 on accept, -1 on pop, both same cycle -> unchanged.
//   Load port: ld_en writes ld_data at ld_addr on edge. Write and read of same word same
//     edge: read returns OLD data. Load permitted at any time, independent of handshakes.
//   busy = (outstanding != 0).
// TESTING
//   Preload words 0..3 = 11111111,22222222,33333333,44444444; requests 0x0,0x4,0x8,0xC
//     back-to-back, resp_ready=1 -> four responses consecutive cycles, first LATENCY cycles after accept, in order.
//   req_addr=0x6 -> resp_err=1, resp_instr=0, resp_addr=0x6; next request 0x4 returns 22222222, err=0.
//   req_addr=4*DEPTH_WORDS (0x400 default) -> resp_err=1, resp_instr=0.
//   resp_ready=0, issue 6 requests -> exactly RESP_DEPTH accepted, req_ready=0, resp_* stable;
//     release resp_ready -> all 4 drain in order, req_ready returns 1 after first pop.
//   ld_en to word 2 (55555555) same edge as fetch 0x8 -> response 33333333; refetch -> 55555555.
//   Assert rst_n=0 asynchronously with 3 in flight -> resp_valid=0 immediately, busy=0,
//     no stale responses after release; memory contents retained.

Source files
------------

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : imem_responder
//  Purpose  : Instruction-memory responder, the target end of the PC unit's
//             fetch interface. Word fetches (byte address) are accepted over
//             valid/ready. Each returns its 32-bit instruction after a fixed
//             pipeline latency. A response FIFO absorbs consumer back-pressure.
//             A word-write load port preloads the program.
//  Ports    : clk, rst_n                      clock, async active-low reset
//             req_valid/req_ready/req_addr    fetch request channel
//             resp_valid/resp_ready           response handshake
//             resp_instr/resp_addr/resp_err   response payload
//             ld_en/ld_addr/ld_data           program load port (word index)
//             busy                            requests outstanding
//  Revision : 1.0  initial release
// ============================================================================
module imem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2,
    parameter int RESP_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [31:0]                    req_addr,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [31:0]                    resp_instr,
    output logic [31:0]                    resp_addr,
    output logic                           resp_err,
    input  logic                           ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
    input  logic [31:0]                    ld_data,
    output logic                           busy
);

    localparam int c_ADDR_W = $clog2(DEPTH_WORDS);
    localparam int c_PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int c_CNT_W  = $clog2(RESP_DEPTH + 1);

    // ------------------------------------------------------------------
    // Instruction storage (not reset). The read is combinational in the
    // accept cycle, so a load to the same word on that edge is seen only
    // by later fetches.
    // ------------------------------------------------------------------
    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (ld_en) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

    logic        w_accept;
    logic        w_err;
    logic [31:0] w_rd_instr;

    assign w_accept   = req_valid & req_ready;
    assign w_err      = (req_addr[1:0] != 2'b00) || ((req_addr >> 2) >= 32'(DEPTH_WORDS));
    assign w_rd_instr = w_err ? 32'h0 : r_mem[req_addr[2 +: c_ADDR_W]];

    // ------------------------------------------------------------------
    // Latency pipeline. The FIFO write itself supplies one cycle of
    // latency, so only LATENCY-1 register stages sit in front of it.
    // ------------------------------------------------------------------
    logic        w_push;
    logic [31:0] w_push_instr;
    logic [31:0] w_push_addr;
    logic        w_push_err;

    generate
        if (LATENCY == 1) begin : g_direct
            assign w_push       = w_accept;
            assign w_push_instr = w_rd_instr;
            assign w_push_addr  = req_addr;
            assign w_push_err   = w_err;
        end else begin : g_pipe
            logic [LATENCY-2:0] r_vld;
            logic [LATENCY-2:0] r_er;
            logic [31:0]        r_ins [LATENCY-1];
            logic [31:0]        r_adr [LATENCY-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld <= '0;
                end else begin
                    r_vld[0] <= w_accept;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        r_vld[i] <= r_vld[i-1];
                    end
                end
            end

            // Payload needs no reset: it is qualified by r_vld.
            always_ff @(posedge clk) begin
                r_ins[0] <= w_rd_instr;
                r_adr[0] <= req_addr;
                r_er[0]  <= w_err;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    r_ins[i] <= r_ins[i-1];
                    r_adr[i] <= r_adr[i-1];
                    r_er[i]  <= r_er[i-1];
                end
            end

            assign w_push       = r_vld[LATENCY-2];
            assign w_push_instr = r_ins[LATENCY-2];
            assign w_push_addr  = r_adr[LATENCY-2];
            assign w_push_err   = r_er[LATENCY-2];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Response FIFO. Credits (outstanding < RESP_DEPTH) reserve a slot for
    // every request in flight, so a push never meets a full FIFO.
    // ------------------------------------------------------------------
    logic [31:0]         r_f_instr [RESP_DEPTH];
    logic [31:0]         r_f_addr  [RESP_DEPTH];
    logic [RESP_DEPTH-1:0] r_f_err;
    logic [c_PTR_W-1:0]  r_wptr;
    logic [c_PTR_W-1:0]  r_rptr;
    logic [c_CNT_W-1:0]  r_fcnt;
    logic [c_CNT_W-1:0]  r_outst;
    logic                w_pop;

    function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(RESP_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign w_pop = resp_valid & resp_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_f_instr[r_wptr] <= w_push_instr;
            r_f_addr[r_wptr]  <= w_push_addr;
            r_f_err[r_wptr]   <= w_push_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_fcnt  <= '0;
            r_outst <= '0;
        end else begin
            if (w_push) r_wptr <= f_next(r_wptr);
            if (w_pop)  r_rptr <= f_next(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + c_CNT_W'(1);
                2'b01:   r_fcnt <= r_fcnt - c_CNT_W'(1);
                default: r_fcnt <= r_fcnt;
            endcase
            case ({w_accept, w_pop})
                2'b10:   r_outst <= r_outst + c_CNT_W'(1);
                2'b01:   r_outst <= r_outst - c_CNT_W'(1);
                default: r_outst <= r_outst;
            endcase
        end
    end

    // Payload is forced to zero while empty so idle/reset outputs are clean.
    assign resp_valid = (r_fcnt != '0);
    assign resp_instr = resp_valid ? r_f_instr[r_rptr] : 32'h0;
    assign resp_addr  = resp_valid ? r_f_addr[r_rptr]  : 32'h0;
    assign resp_err   = resp_valid & r_f_err[r_rptr];
    assign req_ready  = (r_outst < c_CNT_W'(RESP_DEPTH));
    assign busy       = (r_outst != '0);

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_responder
//  Purpose  : Self-checking bench for imem_responder. A transaction-level
//             model (queue of accepted fetches, each tagged with the cycle it
//             becomes visible) predicts every output each cycle. Directed
//             scenarios pin the model with literal expectations, and a
//             randomized phase follows.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imem_responder;

    localparam int DEPTH_WORDS = 256;
    localparam int LATENCY     = 2;
    localparam int RESP_DEPTH  = 4;
    localparam int c_AW        = $clog2(DEPTH_WORDS);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [31:0]     req_addr = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [31:0]     resp_instr;
    logic [31:0]     resp_addr;
    logic            resp_err;
    logic            ld_en = 1'b0;
    logic [c_AW-1:0] ld_addr = '0;
    logic [31:0]     ld_data = '0;
    logic            busy;

    imem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .LATENCY     (LATENCY),
        .RESP_DEPTH  (RESP_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_instr (resp_instr),
        .resp_addr  (resp_addr),
        .resp_err   (resp_err),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ---------------- model state ----------------
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
        int          rdy;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mmem [DEPTH_WORDS];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    // Log of responses actually popped from the DUT
    logic [31:0] log_instr[$];
    logic [31:0] log_addr[$];
    logic        log_err[$];
    int          log_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        logic ev;
        ev = (q.size() > 0) && (q[0].rdy <= cyc);
        chk("req_ready", {31'b0, req_ready}, {31'b0, q.size() < RESP_DEPTH});
        chk("busy", {31'b0, busy}, {31'b0, q.size() != 0});
        chk("resp_valid", {31'b0, resp_valid}, {31'b0, ev});
        if (ev && resp_valid) begin
            chk("resp_instr", resp_instr, q[0].instr);
            chk("resp_addr", resp_addr, q[0].addr);
            chk("resp_err", {31'b0, resp_err}, {31'b0, q[0].err});
        end
    endtask

    // One clock cycle: drive inputs, advance the model, check at negedge.
    task automatic tick(input logic v, input logic [31:0] a, input logic rr,
                        input logic le, input logic [c_AW-1:0] la, input logic [31:0] ld);
        ent_t e;
        logic ev;
        logic er;
        req_valid  = v;
        req_addr   = a;
        resp_ready = rr;
        ld_en      = le;
        ld_addr    = la;
        ld_data    = ld;
        if (resp_valid && resp_ready) begin
            log_instr.push_back(resp_instr);
            log_addr.push_back(resp_addr);
            log_err.push_back(resp_err);
            log_cyc.push_back(cyc);
        end
        er = (q.size() < RESP_DEPTH);
        ev = (q.size() > 0) && (q[0].rdy <= cyc);
        if (ev && rr) void'(q.pop_front());
        if (v && er) begin
            e.err   = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH_WORDS);
            e.instr = e.err ? 32'h0 : mmem[a[2 +: c_AW]];
            e.addr  = a;
            e.rdy   = cyc + LATENCY;
            q.push_back(e);
        end
        if (le) mmem[la] = ld;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) tick(1'b0, 32'h0, rr, 1'b0, '0, 32'h0);
    endtask

    int          base;
    int          c0;
    logic [31:0] exp4 [4];
    logic [31:0] a;
    int          r;

    initial begin
        // ---------------- reset ----------------
        @(negedge clk);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_resp_instr", resp_instr, 32'h0);
        chk("rst_resp_addr", resp_addr, 32'h0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
        rst_n = 1'b1;

        // ---------------- preload ----------------
        exp4[0] = 32'h11111111; exp4[1] = 32'h22222222;
        exp4[2] = 32'h33333333; exp4[3] = 32'h44444444;
        for (int i = 0; i < DEPTH_WORDS; i++)
            tick(1'b0, 32'h0, 1'b1, 1'b1, c_AW'(i), (i < 4) ? exp4[i] : $urandom);

        // ---------------- back-to-back fetch ----------------
        base = log_instr.size();
        c0   = cyc;
        for (int i = 0; i < 4; i++) tick(1'b1, 32'(4 * i), 1'b1, 1'b0, '0, 32'h0);
        idle(6, 1'b1);
        chk("b2b_count", 32'(log_instr.size() - base), 32'd4);
        if (log_instr.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("b2b_instr", log_instr[base+i], exp4[i]);
                chk("b2b_cycle", 32'(log_cyc[base+i]), 32'(c0 + LATENCY + i));
            end
        end

        // ---------------- error responses ----------------
        base = log_instr.size();
        tick(1'b1, 32'h6, 1'b1, 1'b0, '0, 32'h0);
        tick(1'b1, 32'h4, 1'b1, 1'b0, '0, 32'h0);
        tick(1'b1, 32'(4 * DEPTH_WORDS), 1'b1, 1'b0, '0, 32'h0);
        idle(6, 1'b1);
        chk("err_count", 32'(log_instr.size() - base), 32'd3);
        if (log_instr.size() >= base + 3) begin
            chk("mis_err", {31'b0, log_err[base]}, 32'h1);
            chk("mis_instr", log_instr[base], 32'h0);
            chk("mis_addr", log_addr[base], 32'h6);
            chk("ok_instr", log_instr[base+1], 32'h22222222);
            chk("ok_err", {31'b0, log_err[base+1]}, 32'h0);
            chk("oob_err", {31'b0, log_err[base+2]}, 32'h1);
            chk("oob_instr", log_instr[base+2], 32'h0);
        end

        // ---------------- back-pressure ----------------
        base = log_instr.size();
        for (int i = 0; i < 6; i++) tick(1'b1, 32'(4 * (i % 4)), 1'b0, 1'b0, '0, 32'h0);
        chk("bp_accepted", 32'(q.size()), 32'(RESP_DEPTH));
        chk("bp_ready_low", {31'b0, req_ready}, 32'h0);
        tick(1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0);
        chk("bp_ready_back", {31'b0, req_ready}, 32'h1);
        idle(8, 1'b1);
        chk("bp_count", 32'(log_instr.size() - base), 32'd4);
        if (log_instr.size() >= base + 4)
            for (int i = 0; i < 4; i++) chk("bp_order", log_instr[base+i], exp4[i]);

        // ---------------- load / read collision ----------------
        base = log_instr.size();
        tick(1'b1, 32'h8, 1'b1, 1'b1, c_AW'(2), 32'h55555555);
        idle(3, 1'b1);
        tick(1'b1, 32'h8, 1'b1, 1'b0, '0, 32'h0);
        idle(4, 1'b1);
        chk("coll_count", 32'(log_instr.size() - base), 32'd2);
        if (log_instr.size() >= base + 2) begin
            chk("coll_old", log_instr[base], 32'h33333333);
            chk("coll_new", log_instr[base+1], 32'h55555555);
        end

        // ---------------- randomized traffic ----------------
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, DEPTH_WORDS - 1)) << 2;
            else if (r == 7) a = (32'($urandom_range(0, DEPTH_WORDS - 1)) << 2) | 32'($urandom_range(1, 3));
            else             a = 32'(4 * DEPTH_WORDS) + (32'($urandom_range(0, 1000)) << 2);
            tick(($urandom_range(0, 2) != 0), a, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) == 0), c_AW'($urandom_range(8, DEPTH_WORDS - 1)), $urandom);
        end
        idle(10, 1'b1);

        // ---------------- asynchronous reset mid-operation ----------------
        for (int i = 0; i < 3; i++) tick(1'b1, 32'(4 * i), 1'b0, 1'b0, '0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("arst_busy", {31'b0, busy}, 32'h0);
        chk("arst_req_ready", {31'b0, req_ready}, 32'h1);
        q.delete();
        idle(1, 1'b1);
        rst_n = 1'b1;
        base = log_instr.size();
        idle(5, 1'b1);
        chk("arst_no_stale", 32'(log_instr.size() - base), 32'd0);
        tick(1'b1, 32'h0, 1'b1, 1'b0, '0, 32'h0);
        tick(1'b1, 32'h4, 1'b1, 1'b0, '0, 32'h0);
        idle(5, 1'b1);
        chk("arst_count", 32'(log_instr.size() - base), 32'd2);
        if (log_instr.size() >= base + 2) begin
            chk("arst_mem0", log_instr[base], 32'h11111111);
            chk("arst_mem1", log_instr[base+1], 32'h22222222);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
